// File: rtl/button_event_scheduler_pkg.sv
// Shared defaults, FSM encoding and event field widths
// for the button event scheduler.
package button_event_scheduler_pkg;

    localparam int DEF_DELAY      = 500000;
    localparam int DEF_NUM_BTN    = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int EVT_PRESS_W = 1;

    function automatic int evt_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int evt_w(input int n);
        return evt_id_w(n) + EVT_PRESS_W;
    endfunction

    typedef enum logic [1:0] {
        SCAN   = 2'd0,
        SETTLE = 2'd1,
        COMMIT = 2'd2
    } sched_state_t;

endpackage

// File: rtl/event_fifo.sv
// Synchronous event queue with valid/ready head and
// push accepted on full when a pop happens the same cycle.
module event_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop_ready,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    used;
    logic             pop;
    logic             wr_en;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (used == CW'(DEPTH));
    assign head_valid = (used != '0);
    assign head_data  = mem[rd_ptr];
    assign pop        = head_valid && pop_ready;
    assign wr_en      = push && (!full || pop);

    always_ff @(posedge clock) begin
        if (wr_en)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= bump(wr_ptr);
            if (pop)
                rd_ptr <= bump(rd_ptr);
            case ({wr_en, pop})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: used <= used;
            endcase
        end
    end

endmodule

// File: rtl/button_event_scheduler.sv
// Debounces a bank of buttons with one shared counter and
// queues press/release events in commit order.
module button_event_scheduler
    import button_event_scheduler_pkg::*;
#(
    parameter int DELAY      = DEF_DELAY,
    parameter int NUM_BTN    = DEF_NUM_BTN,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_BTN-1:0]         btn_raw,
    input  logic                       evt_ready,
    input  logic                       ovf_clr,
    output logic                       evt_valid,
    output logic [$clog2(NUM_BTN)-1:0] evt_id,
    output logic                       evt_press,
    output logic [NUM_BTN-1:0]         btn_state,
    output logic                       overflow
);

    localparam int IW = $clog2(NUM_BTN);
    localparam int CW = $clog2(DELAY + 1);
    localparam int EW = evt_w(NUM_BTN);

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;

    sched_state_t state, state_d;
    logic [IW-1:0] ptr, ptr_d;
    logic [IW-1:0] cand_id, cand_id_d;
    logic          cand_lvl, cand_lvl_d;
    logic [CW-1:0] count, count_d;
    logic          commit;
    logic          full;
    logic          drop;
    logic [EW-1:0] head;

    always_comb begin
        state_d    = state;
        ptr_d      = ptr;
        cand_id_d  = cand_id;
        cand_lvl_d = cand_lvl;
        count_d    = count;
        commit     = 1'b0;
        unique case (state)
            SCAN: begin
                if (sync2[ptr] != btn_state[ptr]) begin
                    cand_id_d  = ptr;
                    cand_lvl_d = sync2[ptr];
                    count_d    = '0;
                    state_d    = SETTLE;
                end else begin
                    ptr_d = ptr + 1'b1;
                end
            end
            SETTLE: begin
                if (sync2[cand_id] != cand_lvl) begin
                    ptr_d   = cand_id + 1'b1;
                    state_d = SCAN;
                end else if (count == CW'(DELAY - 1)) begin
                    state_d = COMMIT;
                end else begin
                    count_d = count + 1'b1;
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                ptr_d   = cand_id + 1'b1;
                state_d = SCAN;
            end
            default: state_d = SCAN;
        endcase
    end

    // a full queue still takes the push if the head leaves this cycle
    assign drop = commit && full && !(evt_valid && evt_ready);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1     <= '0;
            sync2     <= '0;
            state     <= SCAN;
            ptr       <= '0;
            cand_id   <= '0;
            cand_lvl  <= 1'b0;
            count     <= '0;
            btn_state <= '0;
            overflow  <= 1'b0;
        end else begin
            sync1    <= btn_raw;
            sync2    <= sync1;
            state    <= state_d;
            ptr      <= ptr_d;
            cand_id  <= cand_id_d;
            cand_lvl <= cand_lvl_d;
            count    <= count_d;
            if (commit)
                btn_state[cand_id] <= cand_lvl;
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    event_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (commit),
        .push_data  ({cand_id, cand_lvl}),
        .full       (full),
        .pop_ready  (evt_ready),
        .head_valid (evt_valid),
        .head_data  (head)
    );

    assign evt_id    = head[EW-1:1];
    assign evt_press = head[0];

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler with
// DELAY=8, four buttons and a four-entry queue.
module tb_button_event_scheduler;

    localparam int DELAY = 8;
    localparam int NB    = 4;
    localparam int FD    = 4;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] btn_raw = '0;
    logic          evt_ready = 1'b0;
    logic          ovf_clr = 1'b0;
    logic          evt_valid;
    logic [1:0]    evt_id;
    logic          evt_press;
    logic [NB-1:0] btn_state;
    logic          overflow;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int ref_ptr = 0;
    int ref_cyc = 0;
    logic [2:0] sb [$];

    button_event_scheduler #(
        .DELAY      (DELAY),
        .NUM_BTN    (NB),
        .FIFO_DEPTH (FD)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .btn_raw   (btn_raw),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_press (evt_press),
        .btn_state (btn_state),
        .overflow  (overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // handshake monitor: pops the scoreboard on every accepted event
    always @(negedge clock) begin
        if (reset_n && evt_valid && evt_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_evt: got id=%0d press=%0d, expected none",
                         evt_id, evt_press);
            end else begin
                check("evt", int'({evt_id, evt_press}), int'(sb.pop_front()));
            end
        end
    end

    function automatic int ptr_at(input int e);
        return (ref_ptr + e - ref_cyc) % NB;
    endfunction

    task automatic wait_state(input int i, input logic lvl,
                              input string nm, output int at);
        int k;
        at = -1;
        k = 0;
        while (at < 0 && k < 200) begin
            @(posedge clock);
            #1;
            if (btn_state[i] === lvl)
                at = cyc;
            k++;
        end
        if (at < 0) begin
            tests++;
            fails++;
            $display("FAIL %s: btn_state[%0d] never reached %0d", nm, i, lvl);
        end else begin
            ref_ptr = (i + 1) % NB;
            ref_cyc = at;
        end
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clock);
            #1;
            k++;
        end
        check(nm, sb.size(), 0);
    endtask

    task automatic to_cycle(input int e);
        while (cyc < e) begin
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        int d, v, p, s0, s1, a1, a2, first, second, pe, k;
        logic seen;
        int ids [5];
        logic lvls [5];

        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", evt_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_state", btn_state, 0);
        reset_n = 1'b1;
        ref_ptr = 0;
        ref_cyc = cyc;

        // clean press of button 2 with the pointer arriving on it
        evt_ready = 1'b1;
        @(posedge clock);
        #1;
        while (ptr_at(cyc + 2) != 2) begin
            @(posedge clock);
            #1;
        end
        d = cyc;
        btn_raw[2] = 1'b1;
        sb.push_back({2'd2, 1'b1});
        v = -1;
        k = 0;
        while (v < 0 && k < 100) begin
            @(posedge clock);
            #1;
            if (evt_valid)
                v = cyc;
            k++;
        end
        check("lat_b2", v - d, 12);
        check("state_b2", btn_state, 4);
        ref_ptr = 3;
        ref_cyc = v;
        drain("drain_b2");

        // bouncing button 1
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_raw[1] = ~btn_raw[1];
            repeat (3) begin
                @(posedge clock);
                #1;
                if (btn_state[1])
                    seen = 1'b1;
            end
        end
        btn_raw[1] = 1'b1;
        sb.push_back({2'd1, 1'b1});
        check("bounce_nochg", seen, 0);
        wait_state(1, 1'b1, "bounce_commit", a1);
        check("state_b1", btn_state, 6);
        drain("drain_b1");

        // buttons 0 and 3 together
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        d = cyc;
        p = ptr_at(d + 2);
        first = ((4 - p) % 4 < (3 - p + 4) % 4) ? 0 : 3;
        second = (first == 0) ? 3 : 0;
        s0 = (first - p + 4) % 4;
        s1 = (second - (first + 1) + 8) % 4;
        sb.push_back({2'(first), 1'b1});
        sb.push_back({2'(second), 1'b1});
        btn_raw = btn_raw | 4'b1001;
        wait_state(first, 1'b1, "rr_first", a1);
        check("rr_first_lat", a1 - d, 4 + s0 + DELAY);
        wait_state(second, 1'b1, "rr_second", a2);
        check("rr_gap", a2 - a1, s1 + 2 + DELAY);
        check("state_all", btn_state, 15);
        drain("drain_rr");

        // five commits against a stalled consumer
        evt_ready = 1'b0;
        ids = '{0, 1, 2, 3, 2};
        lvls = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            btn_raw[ids[i]] = lvls[i];
            if (i < 4)
                sb.push_back({2'(ids[i]), lvls[i]});
            wait_state(ids[i], lvls[i], "ovf_commit", a1);
        end
        @(posedge clock);
        #1;
        check("ovf_set", overflow, 1);
        check("ovf_state", btn_state, 4);
        check("stall_valid", evt_valid, 1);
        check("stall_id", evt_id, 0);
        evt_ready = 1'b1;
        drain("drain_ovf");
        check("ovf_sticky", overflow, 1);
        ovf_clr = 1'b1;
        @(posedge clock);
        #1;
        ovf_clr = 1'b0;
        check("ovf_clr", overflow, 0);

        // full queue, pop in the commit cycle
        evt_ready = 1'b0;
        ids[0:3] = '{0, 1, 3, 2};
        lvls[0:3] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            btn_raw[ids[i]] = lvls[i];
            sb.push_back({2'(ids[i]), lvls[i]});
            wait_state(ids[i], lvls[i], "fill_commit", a1);
        end
        @(posedge clock);
        #1;
        d = cyc;
        p = ptr_at(d + 2);
        s0 = (0 - p + 4) % 4;
        pe = d + 4 + s0 + DELAY;
        btn_raw[0] = 1'b0;
        sb.push_back({2'd0, 1'b0});
        to_cycle(pe - 1);
        evt_ready = 1'b1;
        @(posedge clock);
        #1;
        evt_ready = 1'b0;
        check("full_push_state", btn_state, 10);
        check("full_push_ovf", overflow, 0);
        check("full_push_head", evt_id, 1);
        evt_ready = 1'b1;
        drain("drain_full");
        check("full_ovf_end", overflow, 0);

        // reset in the middle of a settle with an event queued
        evt_ready = 1'b0;
        btn_raw[2] = 1'b1;
        wait_state(2, 1'b1, "pre_rst_commit", a1);
        check("pre_rst_valid", evt_valid, 1);
        btn_raw[2] = 1'b0;
        repeat (6) @(posedge clock);
        #3;
        reset_n = 1'b0;
        btn_raw = 4'b0010;
        #1;
        check("midrst_valid", evt_valid, 0);
        check("midrst_ovf", overflow, 0);
        check("midrst_state", btn_state, 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        sb.push_back({2'd1, 1'b1});
        evt_ready = 1'b1;
        wait_state(1, 1'b1, "post_rst_commit", a1);
        drain("drain_rst");
        check("post_rst_state", btn_state, 2);

        repeat (20) @(posedge clock);
        #1;
        check("leftover", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
